// File: rtl/cmd_sequencer_pkg.sv
// Shared types for the command sequencer: op-class and state encodings, op_code field layout.
// Optional trap behaviour is selected with CMD_SEQUENCER_TRAP_EN (see cmd_sequencer.sv).
package cmd_sequencer_pkg;

    // op_code layout: class in the top CLASS_W bits, source index from bit SRC_LSB upward
    localparam int CLASS_W = 2;
    localparam int SRC_LSB = 0;

    typedef enum logic [CLASS_W-1:0] {
        OP_NOP         = 2'b00,
        OP_WRITE       = 2'b01,
        OP_READ        = 2'b10,
        OP_BURST_WRITE = 2'b11
    } op_class_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SINGLE = 2'b01,
        ST_BURST  = 2'b10,
        ST_TRAP   = 2'b11
    } state_e;

    function automatic int calc_src_w(input int num_src);
        return (num_src > 2) ? $clog2(num_src) : 1;
    endfunction

    function automatic int class_lsb(input int op_w);
        return op_w - CLASS_W;
    endfunction

endpackage

// File: rtl/cmd_sequencer_if.sv
// Command/strobe bus of the sequencer. Handshake: a command transfers on a rising edge where
// op_valid && op_ready; op_code/op_len are sampled only on that edge and may change freely otherwise.
interface cmd_sequencer_if
    import cmd_sequencer_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int LEN_W   = 4
);
    localparam int SRC_W = calc_src_w(NUM_SRC);
    localparam int OP_W  = CLASS_W + SRC_W;

    logic             op_valid;
    logic [OP_W-1:0]  op_code;
    logic [LEN_W-1:0] op_len;
    logic             op_ready;
    logic             write;
    logic             read;
    logic [SRC_W-1:0] source;
    logic [LEN_W-1:0] beat;
    logic             done;
    logic             err;
    logic             err_clr;
    state_e           state_dbg;

    modport master (
        output op_valid, op_code, op_len, err_clr,
        input  op_ready, write, read, source, beat, done, err, state_dbg
    );

    modport slave (
        input  op_valid, op_code, op_len, err_clr,
        output op_ready, write, read, source, beat, done, err, state_dbg
    );

endinterface

// File: rtl/cmd_decode.sv
// Combinational op_code decode: class, source index, and illegal-command detection
// (unknown bits or a source index beyond NUM_SRC-1).
module cmd_decode
    import cmd_sequencer_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int SRC_W   = calc_src_w(NUM_SRC),
    parameter int OP_W    = CLASS_W + SRC_W
) (
    input  logic [OP_W-1:0]  op_code,
    output op_class_e        op_class,
    output logic [SRC_W-1:0] src,
    output logic             illegal
);
    localparam int CLS_LSB = class_lsb(OP_W);

    logic src_range_bad;

    // A power-of-two source count leaves no out-of-range encodings
    generate
        if (NUM_SRC < (1 << SRC_W)) begin : g_range
            assign src_range_bad = (src >= SRC_W'(NUM_SRC));
        end else begin : g_full
            assign src_range_bad = 1'b0;
        end
    endgenerate

    always_comb begin
        op_class = op_class_e'(op_code[CLS_LSB +: CLASS_W]);
        src      = op_code[SRC_LSB +: SRC_W];
        illegal  = $isunknown(op_code) || src_range_bad;
    end

endmodule

// File: rtl/cmd_sequencer.sv
// Command sequencer: turns accepted commands into registered write/read strobes and bursts.
// Define CMD_SEQUENCER_TRAP_EN to make illegal commands sticky (TRAP state until err_clr).
module cmd_sequencer
    import cmd_sequencer_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int LEN_W   = 4
) (
    input logic            clk,
    input logic            rst_n,
    cmd_sequencer_if.slave bus
);
    localparam int SRC_W = calc_src_w(NUM_SRC);
    localparam int OP_W  = CLASS_W + SRC_W;

    op_class_e        dec_class;
    logic [SRC_W-1:0] dec_src;
    logic             dec_illegal;

    cmd_decode #(
        .NUM_SRC(NUM_SRC),
        .SRC_W  (SRC_W),
        .OP_W   (OP_W)
    ) u_decode (
        .op_code (bus.op_code),
        .op_class(dec_class),
        .src     (dec_src),
        .illegal (dec_illegal)
    );

    state_e           state_q, state_d;
    logic             op_ready_q, op_ready_d;
    logic             write_q, write_d;
    logic             read_q, read_d;
    logic [SRC_W-1:0] source_q, source_d;
    logic [LEN_W-1:0] beat_q, beat_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             accept;
    logic [LEN_W-1:0] beat_inc;

    always_comb begin
        state_d  = state_q;
        write_d  = 1'b0;
        read_d   = 1'b0;
        source_d = source_q;
        beat_d   = '0;
        done_d   = 1'b0;
        len_d    = len_q;
`ifdef CMD_SEQUENCER_TRAP_EN
        err_d    = err_q;
`else
        err_d    = 1'b0;
`endif
        accept   = bus.op_valid && op_ready_q;
        beat_inc = beat_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (dec_illegal) begin
                        err_d = 1'b1;
`ifdef CMD_SEQUENCER_TRAP_EN
                        state_d = ST_TRAP;
`endif
                    end else begin
                        case (dec_class)
                            OP_WRITE: begin
                                state_d  = ST_SINGLE;
                                write_d  = 1'b1;
                                source_d = dec_src;
                                done_d   = 1'b1;
                            end
                            OP_READ: begin
                                state_d  = ST_SINGLE;
                                read_d   = 1'b1;
                                source_d = dec_src;
                                done_d   = 1'b1;
                            end
                            OP_BURST_WRITE: begin
                                state_d  = ST_BURST;
                                write_d  = 1'b1;
                                source_d = dec_src;
                                len_d    = bus.op_len;
                                done_d   = (bus.op_len == '0);
                            end
                            default: ;
                        endcase
                    end
                end
            end
            ST_SINGLE: state_d = ST_IDLE;
            ST_BURST: begin
                // Stop on equality so a full-range length never wraps the beat counter
                if (beat_q == len_q) begin
                    state_d = ST_IDLE;
                end else begin
                    write_d = 1'b1;
                    beat_d  = beat_inc;
                    done_d  = (beat_inc == len_q);
                end
            end
            ST_TRAP: begin
`ifdef CMD_SEQUENCER_TRAP_EN
                if (bus.err_clr) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b0;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase

        op_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            op_ready_q <= 1'b1;
            write_q    <= 1'b0;
            read_q     <= 1'b0;
            source_q   <= '0;
            beat_q     <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            len_q      <= '0;
        end else begin
            state_q    <= state_d;
            op_ready_q <= op_ready_d;
            write_q    <= write_d;
            read_q     <= read_d;
            source_q   <= source_d;
            beat_q     <= beat_d;
            done_q     <= done_d;
            err_q      <= err_d;
            len_q      <= len_d;
        end
    end

`ifndef CMD_SEQUENCER_TRAP_EN
    logic unused_err_clr;
    assign unused_err_clr = bus.err_clr;
`endif

    assign bus.op_ready  = op_ready_q;
    assign bus.write     = write_q;
    assign bus.read      = read_q;
    assign bus.source    = source_q;
    assign bus.beat      = beat_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.state_dbg = state_q;

endmodule

// File: doc/cmd_sequencer.md
CMD_SEQUENCER -- requirements
Module: cmd_sequencer

Interface
REQ-001 SHALL have parameter NUM_SRC, default 4, number of selectable sources (2..16).
REQ-002 SHALL have parameter LEN_W, default 4, burst-length field width.
REQ-003 SHALL have derived localparams SRC_W = max(1, clog2(NUM_SRC)) and OP_W = 2 + SRC_W.
REQ-004 SHALL have port: clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port: rst_n  input  1  synchronous, active-low reset.
REQ-006 SHALL have port: op_valid  input  1  command present.
REQ-007 SHALL have port: op_code  input  OP_W  [OP_W-1:OP_W-2] class, [SRC_W-1:0] source index.
REQ-008 SHALL have port: op_len  input  LEN_W  burst beats minus one, sampled with op_code.
REQ-009 SHALL have port: op_ready  output  1  sequencer can accept a command.
REQ-010 SHALL have port: write  output  1  write strobe.
REQ-011 SHALL have port: read  output  1  read strobe.
REQ-012 SHALL have port: source  output  SRC_W  source index for the current strobe.
REQ-013 SHALL have port: beat  output  LEN_W  current burst beat index.
REQ-014 SHALL have port: done  output  1  one-cycle pulse on the last strobe of any command.
REQ-015 SHALL have port: err  output  1  illegal-command indication.
REQ-016 SHALL have port: err_clr  input  1  clears err / trap.

Function
REQ-017 Class encoding SHALL be: 00 NOP, 01 WRITE, 10 READ, 11 BURST_WRITE.
REQ-018 A command SHALL be accepted on a rising edge where op_valid && op_ready.
REQ-019 op_ready SHALL be 1 only in IDLE and SHALL be 0 in all other states.
REQ-020 States SHALL be IDLE, SINGLE, BURST and TRAP.
REQ-021 Transitions SHALL be:
- IDLE -> SINGLE on accepted WRITE/READ;
- IDLE -> BURST on accepted BURST_WRITE;
- SINGLE -> IDLE after 1 cycle;
- BURST -> IDLE after beat == captured op_len.
REQ-022 Accepted NOP SHALL stay in IDLE, produce no strobe and no done.
REQ-023 write/read/source SHALL be registered, asserting the cycle after acceptance (latency 1).
REQ-024 SINGLE SHALL drive exactly one write or read cycle with done=1 in that cycle.
REQ-025 BURST SHALL drive write=1 for op_len+1 consecutive cycles; beat counts 0..op_len; done=1 with the last beat.
REQ-026 source and the captured op_len SHALL be held constant for the whole command regardless of input changes.
REQ-027 op_len = 0 burst SHALL give one beat; op_len = 2^LEN_W-1 SHALL give 2^LEN_W beats with no counter wrap.
REQ-028 Illegal command SHALL be any X/Z bit in op_code (op_valid=1), or source index >= NUM_SRC.
REQ-029 Accepted illegal commands SHALL produce no strobe.
REQ-030 Outside strobe cycles, write=read=0, beat=0 and source holds its last value.
REQ-031 write and read SHALL never be 1 simultaneously.

Reset
REQ-032 On rst_n=0 at a clock edge, the block SHALL go to state IDLE and drive write=0, read=0, source=0, beat=0, done=0, err=0, op_ready=1 from that edge.
REQ-033 Reset mid-burst SHALL abort the burst with no done pulse; reset SHALL take priority over err_clr and acceptance.

Configuration
REQ-034 Macro CMD_SEQUENCER_TRAP_EN defined: an illegal command SHALL set sticky err and enter TRAP (op_ready=0). The block SHALL leave TRAP to IDLE on the edge with err_clr=1, which also clears err.
REQ-035 Macro CMD_SEQUENCER_TRAP_EN undefined: TRAP SHALL not exist; err SHALL pulse 1 cycle after an illegal command and the block SHALL stay in IDLE; err_clr SHALL be ignored.

Structure
REQ-036 Package cmd_sequencer_pkg SHALL hold the op-class enum (NOP/WRITE/READ/BURST_WRITE), the state enum, and class-field bit positions.
REQ-037 Sub-module cmd_decode (combinational class/source/illegal decode) SHALL be instantiated once; all sequential logic stays in cmd_sequencer.

Verification
REQ-038 Reset, then WRITE src 0 (op_code 4'b0100) -> write=1, source=0, done=1 exactly 1 cycle after accept; op_ready back to 1 next cycle.
REQ-039 WRITE src 1 then READ src 2 (4'b1010) issued back-to-back -> second is accepted only when op_ready=1; read=1, source=2; write never overlaps.
REQ-040 BURST src 3, op_len=3 -> write=1 for 4 cycles, beat 0,1,2,3, done only on beat 3; op_code changes during the burst are ignored.
REQ-041 op_code=4'bzz1x -> no strobe; with TRAP_EN err stays 1 and op_ready=0 until err_clr, without TRAP_EN a 1-cycle err pulse.
REQ-042 NUM_SRC=3, op_code source index 3 -> illegal handling per REQ-034/035.
REQ-043 rst_n=0 at beat 2 of an op_len=7 burst -> all outputs at reset values from the next edge, no done.
